// File: rtl/cxs_tx_link_ctrl_if.sv
// Bundle of flit-manager, flit-RAM and CXS TX pin signals around the TX link controller.
// Latency: none (wiring only).
// Backpressure: none; flow control is by CXS credits carried on cxs_crdgnt/cxs_crdrtn.
interface cxs_tx_link_ctrl_if #(
  parameter int FLIT_WIDTH = 256
);
  logic                  link_en;
  logic                  read_req;
  logic [3:0]            read_addr;
  logic                  flit_valid;
  logic                  mem_rd_en;
  logic [3:0]            mem_rd_addr;
  logic [FLIT_WIDTH-1:0] mem_rd_data;
  logic                  credit_avail;
  logic                  link_up;
  logic                  cxs_active_req;
  logic                  cxs_active_ack;
  logic                  cxs_valid;
  logic [FLIT_WIDTH-1:0] cxs_data;
  logic                  cxs_crdgnt;
  logic                  cxs_crdrtn;
  logic [3:0]            crd_cnt;
  logic                  err_flag;

  // Controller side
  modport master (
    input  link_en, read_req, read_addr, flit_valid, mem_rd_data, cxs_active_ack, cxs_crdgnt,
    output mem_rd_en, mem_rd_addr, credit_avail, link_up, cxs_active_req, cxs_valid,
           cxs_data, cxs_crdrtn, crd_cnt, err_flag
  );

  // Flit manager / RAM / link partner side
  modport slave (
    output link_en, read_req, read_addr, flit_valid, mem_rd_data, cxs_active_ack, cxs_crdgnt,
    input  mem_rd_en, mem_rd_addr, credit_avail, link_up, cxs_active_req, cxs_valid,
           cxs_data, cxs_crdrtn, crd_cnt, err_flag
  );
endinterface

// File: rtl/cxs_tx_link_ctrl.sv
// CXS TX link controller: link-activation FSM, TX credit counter, flit-RAM fetch and CXS beat.
// Latency: read_req -> mem_rd_en +1; cxs_valid one cycle after pending flit and RAM data meet.
// Backpressure: credit based; read_req without a free credit is dropped and flagged in err_flag.
module cxs_tx_link_ctrl #(
  parameter int FLIT_WIDTH  = 256,
  parameter int MAX_CREDITS = 15,
  parameter int RD_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cxs_tx_link_ctrl_if.master bus
);

  typedef enum logic [1:0] {ST_STOP, ST_ACTIVATE, ST_RUN, ST_DEACTIVATE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              crd_q, crd_d;
  logic                    resv_q, resv_d;
  logic                    pend_q, pend_d;
  logic                    rdy_q, rdy_d;
  logic                    err_q, err_d;
  logic                    rd_en_q, rd_en_d;
  logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
  logic [FLIT_WIDTH-1:0]   hold_q, hold_d;
  logic                    valid_q, valid_d;
  logic [FLIT_WIDTH-1:0]   data_q, data_d;
  logic                    crdrtn_q, crdrtn_d;
  logic                    link_up_q, link_up_d;
  logic                    avail_q, avail_d;
  logic                    act_req_q, act_req_d;

  logic take, gnt, rtn, dec, fv_ok, cap, fire, at_max;

  // A read is accepted only with a free credit and no flit already reserved.
  assign take   = bus.read_req & (crd_q != 4'd0) & ~resv_q;
  assign gnt    = bus.cxs_crdgnt & (state_q != ST_STOP);
  // Credits are handed back only once any reserved flit has gone out.
  assign rtn    = (state_q == ST_DEACTIVATE) & ~resv_q & (crd_q != 4'd0) & ~take;
  assign dec    = take | rtn;
  assign at_max = (crd_q == 4'(MAX_CREDITS));
  assign fv_ok  = bus.flit_valid & resv_q & ~pend_q;
  // RAM data is valid in the cycle RD_LATENCY cycles after the strobe cycle.
  assign cap    = pipe_q[RD_LATENCY-1];
  // Data arriving this cycle can be forwarded directly, saving a cycle.
  assign fire   = pend_q & (rdy_q | cap);

  // Next-state logic: link FSM, credit accounting, fetch/transmit flags, registered outputs.
  always_comb begin
    state_d   = state_q;
    crd_d     = crd_q;
    resv_d    = resv_q;
    pend_d    = pend_q;
    rdy_d     = rdy_q;
    err_d     = err_q;
    hold_d    = hold_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    crdrtn_d  = rtn;
    rd_en_d   = take;
    pipe_d    = (pipe_q << 1) | RD_LATENCY'(rd_en_q);

    if (bus.read_req && !take)            err_d = 1'b1;
    if (bus.flit_valid && !resv_q)        err_d = 1'b1;

    // A grant and a decrement in the same cycle cancel out.
    if (gnt && !dec) begin
      if (at_max) err_d = 1'b1;
      else        crd_d = crd_q + 4'd1;
    end else if (!gnt && dec) begin
      crd_d = crd_q - 4'd1;
    end

    if (take)  resv_d = 1'b1;
    if (fv_ok) pend_d = 1'b1;
    if (cap) begin
      hold_d = bus.mem_rd_data;
      rdy_d  = 1'b1;
    end
    if (fire) begin
      valid_d = 1'b1;
      data_d  = rdy_q ? hold_q : bus.mem_rd_data;
      pend_d  = 1'b0;
      rdy_d   = 1'b0;
      resv_d  = 1'b0;
    end

    unique case (state_q)
      ST_STOP:       if (bus.link_en) state_d = ST_ACTIVATE;
      ST_ACTIVATE: begin
        if (!bus.link_en)            state_d = ST_DEACTIVATE;
        else if (bus.cxs_active_ack) state_d = ST_RUN;
      end
      ST_RUN:        if (!bus.link_en) state_d = ST_DEACTIVATE;
      ST_DEACTIVATE: if (!bus.cxs_active_ack && crd_q == 4'd0 && !resv_q) state_d = ST_STOP;
      default:       state_d = ST_STOP;
    endcase

    link_up_d = (state_d == ST_RUN);
    act_req_d = (state_d == ST_ACTIVATE) || (state_d == ST_RUN);
    avail_d   = link_up_d & (crd_d != 4'd0) & ~resv_d;
  end

  // State register; reset also kills any fetch still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      crd_q     <= '0;
      resv_q    <= 1'b0;
      pend_q    <= 1'b0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      pipe_q    <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      crdrtn_q  <= 1'b0;
      link_up_q <= 1'b0;
      avail_q   <= 1'b0;
      act_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crd_q     <= crd_d;
      resv_q    <= resv_d;
      pend_q    <= pend_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      pipe_q    <= pipe_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      crdrtn_q  <= crdrtn_d;
      link_up_q <= link_up_d;
      avail_q   <= avail_d;
      act_req_q <= act_req_d;
    end
  end

  assign bus.mem_rd_en      = rd_en_q;
  // The flit manager only presents the slot on the strobe cycle, so it is passed straight through.
  assign bus.mem_rd_addr    = rd_en_q ? bus.read_addr : 4'd0;
  assign bus.credit_avail   = avail_q;
  assign bus.link_up        = link_up_q;
  assign bus.cxs_active_req = act_req_q;
  assign bus.cxs_valid      = valid_q;
  assign bus.cxs_data       = data_q;
  assign bus.cxs_crdrtn     = crdrtn_q;
  assign bus.crd_cnt        = crd_q;
  assign bus.err_flag       = err_q;

endmodule

// File: tb/tb_cxs_tx_link_ctrl.sv
// Self-checking bench for the CXS TX link controller with a latency-accurate flit RAM model.
// Latency: RAM returns data RD_LATENCY cycles after the strobe cycle.
// Backpressure: none; the bench issues reads only when its own credit model allows.
module tb_cxs_tx_link_ctrl;
  localparam int FW = 256;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  cxs_tx_link_ctrl_if #(.FLIT_WIDTH(FW)) bus();

  cxs_tx_link_ctrl #(.FLIT_WIDTH(FW), .MAX_CREDITS(15), .RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] ram [16];
  logic          hv [L+1] = '{default: 1'b0};
  logic [3:0]    ha [L+1] = '{default: 4'd0};

  function automatic logic [FW-1:0] rnd_flit();
    logic [FW-1:0] v;
    for (int i = 0; i < FW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // RAM: data for the strobe seen in cycle c is presented throughout cycle c+L, garbage otherwise.
  always @(posedge clk) begin
    #2;
    for (int i = L; i > 0; i--) begin hv[i] = hv[i-1]; ha[i] = ha[i-1]; end
    hv[0] = bus.mem_rd_en;
    ha[0] = bus.mem_rd_addr;
    bus.mem_rd_data = hv[L] ? ram[ha[L]] : rnd_flit();
  end

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic clear_inputs();
    bus.link_en = 0; bus.read_req = 0; bus.read_addr = 0; bus.flit_valid = 0;
    bus.cxs_active_ack = 0; bus.cxs_crdgnt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0; tick(); tick(); rst_n = 1; tick();
  endtask

  task automatic link_bring_up();
    bus.link_en = 1; tick(); bus.cxs_active_ack = 1; tick();
  endtask

  task automatic grant_n(input int n);
    bus.cxs_crdgnt = 1; repeat (n) tick(); bus.cxs_crdgnt = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); rst_n = 0; #3;
    checks++; if ({bus.mem_rd_en, bus.credit_avail, bus.link_up, bus.cxs_active_req, bus.cxs_valid, bus.cxs_crdrtn, bus.err_flag} !== 7'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000000", {bus.mem_rd_en, bus.credit_avail, bus.link_up, bus.cxs_active_req, bus.cxs_valid, bus.cxs_crdrtn, bus.err_flag}); end
    checks++; if (bus.crd_cnt !== 4'd0 || bus.mem_rd_addr !== 4'd0) begin errors++; $display("FAIL rst_cnt_addr got=%0d/%0d exp=0/0", bus.crd_cnt, bus.mem_rd_addr); end
    checks++; if (bus.cxs_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", bus.cxs_data); end
    tick(); tick(); rst_n = 1; tick(); tick();
    checks++; if (bus.cxs_active_req !== 1'b0 || bus.crd_cnt !== 4'd0) begin errors++; $display("FAIL rst_idle got req=%b crd=%0d exp req=0 crd=0", bus.cxs_active_req, bus.crd_cnt); end
  endtask

  task automatic test_bring_up();
    bus.link_en = 1; tick();
    checks++; if (bus.cxs_active_req !== 1'b1 || bus.link_up !== 1'b0) begin errors++; $display("FAIL bu_req got req=%b up=%b exp req=1 up=0", bus.cxs_active_req, bus.link_up); end
    tick(); tick(); tick(); bus.cxs_active_ack = 1;
    checks++; if (bus.link_up !== 1'b0) begin errors++; $display("FAIL bu_early_up got=%b exp=0", bus.link_up); end
    tick();
    checks++; if (bus.link_up !== 1'b1 || bus.credit_avail !== 1'b0) begin errors++; $display("FAIL bu_up got up=%b ca=%b exp up=1 ca=0", bus.link_up, bus.credit_avail); end
    tick();
    checks++; if (bus.credit_avail !== 1'b0) begin errors++; $display("FAIL bu_ca_nocrd got=%b exp=0", bus.credit_avail); end
    grant_n(1);
    checks++; if (bus.crd_cnt !== 4'd1 || bus.credit_avail !== 1'b1) begin errors++; $display("FAIL bu_first_crd got crd=%0d ca=%b exp crd=1 ca=1", bus.crd_cnt, bus.credit_avail); end
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] pat;
    pat = {32{8'hA5}}; ram[5] = pat;
    grant_n(1);
    checks++; if (bus.crd_cnt !== 4'd2) begin errors++; $display("FAIL sf_crd2 got=%0d exp=2", bus.crd_cnt); end
    bus.read_req = 1; tick();
    bus.read_req = 0; bus.read_addr = 5; #1;
    checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 4'd5) begin errors++; $display("FAIL sf_rd got en=%b addr=%0d exp en=1 addr=5", bus.mem_rd_en, bus.mem_rd_addr); end
    checks++; if (bus.crd_cnt !== 4'd1 || bus.credit_avail !== 1'b0) begin errors++; $display("FAIL sf_resv got crd=%0d ca=%b exp crd=1 ca=0", bus.crd_cnt, bus.credit_avail); end
    tick(); bus.read_addr = 4'($urandom_range(0, 15)); bus.flit_valid = 1;
    checks++; if (bus.mem_rd_en !== 1'b0 || bus.credit_avail !== 1'b0 || bus.cxs_valid !== 1'b0) begin errors++; $display("FAIL sf_t2 got en=%b ca=%b v=%b exp 0/0/0", bus.mem_rd_en, bus.credit_avail, bus.cxs_valid); end
    tick(); bus.flit_valid = 0;
    checks++; if (bus.cxs_valid !== 1'b0 || bus.credit_avail !== 1'b0) begin errors++; $display("FAIL sf_t3 got v=%b ca=%b exp 0/0", bus.cxs_valid, bus.credit_avail); end
    tick();
    checks++; if (bus.cxs_valid !== 1'b1 || bus.cxs_data !== pat) begin errors++; $display("FAIL sf_beat got v=%b data=%h exp v=1 data=%h", bus.cxs_valid, bus.cxs_data, pat); end
    checks++; if (bus.credit_avail !== 1'b1 || bus.crd_cnt !== 4'd1) begin errors++; $display("FAIL sf_after got ca=%b crd=%0d exp ca=1 crd=1", bus.credit_avail, bus.crd_cnt); end
    tick();
    checks++; if (bus.cxs_valid !== 1'b0 || bus.cxs_data !== pat || bus.err_flag !== 1'b0) begin errors++; $display("FAIL sf_hold got v=%b err=%b data=%h exp v=0 err=0 data=%h", bus.cxs_valid, bus.err_flag, bus.cxs_data, pat); end
  endtask

  task automatic test_saturation();
    int e;
    do_reset(); link_bring_up();
    bus.cxs_crdgnt = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      e = (i > 15) ? 15 : i;
      checks++; if (bus.crd_cnt !== 4'(e) || bus.err_flag !== (i >= 16)) begin errors++; $display("FAIL sat_%0d got crd=%0d err=%b exp crd=%0d err=%0d", i, bus.crd_cnt, bus.err_flag, e, (i >= 16)); end
    end
    bus.cxs_crdgnt = 0;
  endtask

  task automatic test_simultaneous();
    bit seen;
    ram[7] = rnd_flit();
    do_reset(); link_bring_up(); grant_n(3);
    bus.read_req = 1; bus.cxs_crdgnt = 1; tick();
    bus.cxs_crdgnt = 0; bus.read_addr = 7;
    checks++; if (bus.crd_cnt !== 4'd3 || bus.credit_avail !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.err_flag !== 1'b0) begin errors++; $display("FAIL sim_resv got crd=%0d ca=%b en=%b err=%b exp 3/0/1/0", bus.crd_cnt, bus.credit_avail, bus.mem_rd_en, bus.err_flag); end
    tick(); bus.read_req = 0; bus.flit_valid = 1;
    checks++; if (bus.err_flag !== 1'b1 || bus.crd_cnt !== 4'd3 || bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL sim_dup_req got err=%b crd=%0d en=%b exp 1/3/0", bus.err_flag, bus.crd_cnt, bus.mem_rd_en); end
    tick(); bus.flit_valid = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (bus.cxs_valid === 1'b1) begin
        seen = 1;
        checks++; if (bus.cxs_data !== ram[7]) begin errors++; $display("FAIL sim_data got=%h exp=%h", bus.cxs_data, ram[7]); end
      end else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL sim_beat got no cxs_valid within 8 cycles exp one beat"); end
  endtask

  task automatic test_teardown();
    int vcyc, first_rtn, nrtn;
    ram[9] = rnd_flit();
    do_reset(); link_bring_up(); grant_n(5);
    bus.read_req = 1; tick();
    bus.read_req = 0; bus.read_addr = 9; bus.link_en = 0;
    checks++; if (bus.crd_cnt !== 4'd4) begin errors++; $display("FAIL td_crd4 got=%0d exp=4", bus.crd_cnt); end
    tick(); bus.read_addr = 0; bus.flit_valid = 1;
    checks++; if (bus.cxs_active_req !== 1'b0 || bus.link_up !== 1'b0) begin errors++; $display("FAIL td_deact got req=%b up=%b exp 0/0", bus.cxs_active_req, bus.link_up); end
    tick(); bus.flit_valid = 0; bus.cxs_active_ack = 0;
    vcyc = -1; first_rtn = -1; nrtn = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cxs_valid === 1'b1) begin
        vcyc = i;
        checks++; if (bus.cxs_data !== ram[9]) begin errors++; $display("FAIL td_data got=%h exp=%h", bus.cxs_data, ram[9]); end
      end
      if (bus.cxs_crdrtn === 1'b1) begin
        if (first_rtn < 0) first_rtn = i;
        nrtn++;
      end
      tick();
    end
    checks++; if (vcyc < 0 || first_rtn <= vcyc) begin errors++; $display("FAIL td_order got beat@%0d first_rtn@%0d exp beat before returns", vcyc, first_rtn); end
    checks++; if (nrtn != 4 || bus.crd_cnt !== 4'd0) begin errors++; $display("FAIL td_returns got n=%0d crd=%0d exp n=4 crd=0", nrtn, bus.crd_cnt); end
    grant_n(1);
    checks++; if (bus.crd_cnt !== 4'd0 || bus.cxs_active_req !== 1'b0) begin errors++; $display("FAIL td_stop got crd=%0d req=%b exp crd=0 req=0", bus.crd_cnt, bus.cxs_active_req); end
  endtask

  task automatic test_async_reset();
    int bad;
    ram[3] = rnd_flit();
    do_reset(); link_bring_up(); grant_n(2);
    bus.read_req = 1; tick();
    bus.read_req = 0; bus.read_addr = 3; tick();
    bus.flit_valid = 1; tick();
    bus.flit_valid = 0; #2; rst_n = 0; #1;
    checks++; if ({bus.mem_rd_en, bus.credit_avail, bus.link_up, bus.cxs_active_req, bus.cxs_valid, bus.cxs_crdrtn, bus.err_flag} !== 7'b0 || bus.crd_cnt !== 4'd0) begin errors++; $display("FAIL ar_clear got flags=%b crd=%0d exp 0/0", {bus.mem_rd_en, bus.credit_avail, bus.link_up, bus.cxs_active_req, bus.cxs_valid, bus.cxs_crdrtn, bus.err_flag}, bus.crd_cnt); end
    tick(); tick(); rst_n = 1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cxs_valid !== 1'b0 || bus.mem_rd_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ar_no_beat got %0d cycles with valid/rd_en exp 0", bad); end
  endtask

  task automatic test_random();
    int  exp_crd, t_t, t_fv, t_v, t_fire;
    bit  exp_ca, exp_err, have, g, rq, bsy;
    logic [3:0] t_addr;
    for (int i = 0; i < 16; i++) ram[i] = rnd_flit();
    do_reset(); link_bring_up();
    exp_crd = 0; exp_ca = 0; exp_err = 0; have = 0; t_t = 0; t_fv = 0; t_v = 0; t_addr = 0;
    for (int n = 0; n < 400; n++) begin
      checks++; if (bus.crd_cnt !== 4'(exp_crd)) begin errors++; $display("FAIL rnd_crd cyc=%0d got=%0d exp=%0d", cyc, bus.crd_cnt, exp_crd); end
      checks++; if (bus.credit_avail !== exp_ca) begin errors++; $display("FAIL rnd_ca cyc=%0d got=%b exp=%b", cyc, bus.credit_avail, exp_ca); end
      checks++; if (bus.cxs_valid !== (have && cyc == t_v)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.cxs_valid, (have && cyc == t_v)); end
      checks++; if (bus.err_flag !== exp_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.err_flag, exp_err); end
      if (have && cyc == t_v) begin
        checks++; if (bus.cxs_data !== ram[t_addr]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, bus.cxs_data, ram[t_addr]); end
        have = 0;
      end
      g  = ($urandom_range(0, 2) == 0);
      rq = !have && exp_ca && ($urandom_range(0, 1) == 1);
      if (rq) begin
        have = 1; t_t = cyc; t_fv = cyc + int'($urandom_range(1, 4));
        t_fire = (t_fv + 1 > cyc + 1 + L) ? t_fv + 1 : cyc + 1 + L;
        t_v = t_fire + 1; t_addr = 4'($urandom_range(0, 14));
      end
      bus.read_req   = rq;
      bus.flit_valid = have && cyc == t_fv;
      bus.read_addr  = (have && cyc == t_t + 1) ? t_addr : 4'($urandom_range(0, 15));
      bus.cxs_crdgnt = g;
      if (g && !rq) begin
        if (exp_crd == 15) exp_err = 1; else exp_crd++;
      end else if (rq && !g) exp_crd--;
      bsy = have && (cyc + 1 >= t_t + 1) && (cyc + 1 < t_v);
      exp_ca = (exp_crd != 0) && !bsy;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_bring_up();
    test_single_flit();
    test_saturation();
    test_simultaneous();
    test_teardown();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cxs_tx_link_ctrl.md
Name: cxs_tx_link_ctrl

Overview:
Downstream stage of the CXS TX flit manager. It converts that block's read_req/read_addr/flit_valid pulses into a flit-buffer read and a CXS transmit beat. It owns the TX link-activation state machine and the TX credit counter, and reports link_up and credit_avail back to the flit manager. It sits between the flit manager, the TX flit RAM, and the CXS TX pins.

Parameters:
FLIT_WIDTH, 256, width of one flit / CXSDATA
MAX_CREDITS, 15, maximum outstanding TX credits (counter saturates here)
RD_LATENCY, 2, flit RAM read latency in cycles, from mem_rd_en to mem_rd_data valid (1..4)

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  reset; asynchronous assert, active-low, clears all state
link_en  in  1  software request: 1 = bring link up, 0 = take link down
read_req  in  1  1-cycle pulse from flit manager: fetch flit
read_addr  in  4  flit slot 0..14; valid on the cycle after read_req (flit manager updates it one cycle later)
flit_valid  in  1  1-cycle pulse: transmit the fetched flit
mem_rd_en  out  1  flit RAM read strobe
mem_rd_addr  out  4  flit RAM slot
mem_rd_data  in  FLIT_WIDTH  flit RAM read data
credit_avail  out  1  at least one unreserved credit and link in RUN
link_up  out  1  link state is RUN
cxs_active_req  out  1  CXS TXACTIVEREQ
cxs_active_ack  in  1  CXS TXACTIVEACK
cxs_valid  out  1  CXS TX flit valid
cxs_data  out  FLIT_WIDTH  CXS TX flit data
cxs_crdgnt  in  1  CXS TX credit grant, one credit per cycle high
cxs_crdrtn  out  1  credit return pulse during deactivation
crd_cnt  out  4  current unreserved credit count
err_flag  out  1  sticky: credit overflow, or read_req with no credit; cleared only by reset

Behaviour:
- Reset values: every output is 0. Link FSM = STOP. crd_cnt = 0. Reservation flag, pending flag and data-ready flag = 0.
- Link FSM states and transitions:
  - STOP: cxs_active_req=0. link_en=1 -> ACTIVATE.
  - ACTIVATE: cxs_active_req=1. cxs_active_ack=1 -> RUN. link_en=0 -> DEACTIVATE (this takes priority).
  - RUN: cxs_active_req=1, link_up=1. link_en=0 -> DEACTIVATE.
  - DEACTIVATE: cxs_active_req=0, link_up=0.
    - An outstanding reserved flit is still fetched and sent.
    - Once no flit is reserved, return one credit per cycle: cxs_crdrtn=1, crd_cnt-1.
    - Exit to STOP when cxs_active_ack=0, crd_cnt=0 and no reservation.
  - All outputs are registered. link_up follows the state with 1 cycle of latency.
- Credits:
  - cxs_crdgnt accepted in ACTIVATE, RUN and DEACTIVATE; ignored in STOP.
  - Each accepted grant adds 1. At MAX_CREDITS, a grant is dropped and err_flag is set.
  - read_req reserves a credit: crd_cnt-1, reservation flag set.
  - A grant and a reservation in the same cycle leave crd_cnt unchanged.
  - read_req with crd_cnt=0, or while a reservation is already held: ignored, err_flag set.
  - A cxs_valid beat consumes the reservation (reservation flag cleared).
  - credit_avail = link_up & (crd_cnt != 0) & no reservation. This is registered and reflects the next-state values.
- Datapath:
  - read_req at cycle T -> mem_rd_en=1 and mem_rd_addr=read_addr at T+1 (addr is sampled at T+1).
  - mem_rd_data is captured into the holding register at T+1+RD_LATENCY, which sets data-ready.
  - flit_valid sets the pending flag.
  - cxs_valid=1 for exactly one cycle on the cycle after pending & data-ready are both set. cxs_data = holding register; both flags clear.
  - With RD_LATENCY=2 and flit_valid at T+2: cxs_valid at T+4.
- flit_valid with no reservation: ignored, err_flag set.
- cxs_data holds its last value when cxs_valid=0.
- Reset asserted mid-transfer: everything clears immediately, including any in-flight fetch. A pending beat is never emitted after reset deasserts.

Test Plan:
- Bring-up: link_en=1 with ack returned 3 cycles after req -> cxs_active_req=1 one cycle later; link_up=1 one cycle after ack; credit_avail stays 0 until the first crdgnt, then 1.
- Single flit: 2 grants; read_req@T, read_addr=5@T+1, flit_valid@T+2, RAM data=0xA5.. -> mem_rd_en/addr=5 @T+1; cxs_valid @T+4 with data 0xA5..; crd_cnt goes 2->1; credit_avail=0 from T+1 until cxs_valid.
- Saturation: 16 consecutive grants in RUN -> crd_cnt=15, err_flag=1 on the 16th grant.
- Simultaneous: grant on the same cycle as read_req with crd_cnt=3 -> crd_cnt stays 3 and reservation is set.
- Teardown: crd_cnt=4 with a flit reserved, link_en=0 -> flit sent first; then 4 crdrtn pulses; STOP once ack=0; crd_cnt=0.
- Async reset asserted between read_req and cxs_valid -> all outputs 0 immediately; no cxs_valid after release.
